// File: rtl/otp_auth_fsm.sv
// otp_auth_fsm: captures a generated OTP, collects keypad digits, compares them, and reports unlock/fail/expiry.
// Optional feature: define OTP_LOCKOUT_EN to add a timed LOCKOUT state after the attempt limit is reached.
module otp_auth_fsm #(
  parameter int DIGITS         = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int TIMEOUT_CYCLES = 750000000,
  parameter int LOCKOUT_CYCLES = 1000000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DIGITS*DIGIT_W-1:0]         otp_in,
  input  logic                              otp_valid,
  input  logic [DIGIT_W-1:0]                user_digit,
  input  logic                              user_latch,
  input  logic                              user_clear,
  output logic                              unlock,
  output logic                              fail,
  output logic                              expired,
  output logic                              reset_sys,
  output logic                              locked,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts,
  output logic [DIGITS*DIGIT_W-1:0]         user_otp_out
);
  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int AW     = $clog2(MAX_ATTEMPTS + 1);
  localparam int IW     = $clog2(DIGITS + 1);
  // One timer serves both the entry window and the lockout period, so it spans the longer of the two.
  localparam int TSPAN  = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
  localparam int TW     = $clog2(TSPAN);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [AW-1:0] ATT_LIMIT  = AW'(MAX_ATTEMPTS);
`ifdef OTP_LOCKOUT_EN
  localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCKOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ENTER,
`ifdef OTP_LOCKOUT_EN
    LOCKOUT,
`endif
    CHECK
  } state_t;

  state_t              state, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   ubuf_q, ubuf_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [AW-1:0]       att_q, att_d;
  logic                unlock_d, fail_d, expired_d, reset_sys_d;
  logic                timeout, last_latch, match, limit;

  assign timeout    = (state == ENTER) && (timer_q == TIMER_LAST);
  assign last_latch = user_latch && !user_clear && (idx_q == IDX_LAST);
  assign match      = (ubuf_q == code_q);
  assign limit      = ((att_q + AW'(1)) == ATT_LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  state_d = LOAD;
      LOAD:  if (otp_valid) state_d = ENTER;
      ENTER: begin
        if (timeout)         state_d = IDLE;
        else if (last_latch) state_d = CHECK;
      end
      CHECK: begin
        if (match)      state_d = IDLE;
`ifdef OTP_LOCKOUT_EN
        else if (limit) state_d = LOCKOUT;
`else
        else if (limit) state_d = IDLE;
`endif
        else            state_d = ENTER;
      end
`ifdef OTP_LOCKOUT_EN
      LOCKOUT: if (timer_q == LOCK_LAST) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    code_d      = code_q;
    ubuf_d      = ubuf_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    att_d       = att_q;
    unlock_d    = 1'b0;
    fail_d      = 1'b0;
    expired_d   = 1'b0;
    reset_sys_d = 1'b0;
    case (state)
      IDLE: begin
        ubuf_d  = '0;
        idx_d   = '0;
        timer_d = '0;
        att_d   = '0;
      end
      LOAD: if (otp_valid) code_d = otp_in;
      ENTER: begin
        timer_d = timer_q + TW'(1);
        if (timeout) begin
          expired_d = 1'b1;
        end else if (user_clear) begin
          idx_d  = '0;
          ubuf_d = '0;
        end else if (user_latch) begin
          idx_d = idx_q + IW'(1);
          for (int i = 0; i < DIGITS; i++)
            if (idx_q == IW'(i)) ubuf_d[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] = user_digit;
        end
      end
      CHECK: begin
        if (match) begin
          unlock_d = 1'b1;
        end else begin
          // A mismatch always starts from an empty entry, whether retrying or locking out.
          fail_d      = 1'b1;
          att_d       = att_q + AW'(1);
          reset_sys_d = limit;
          idx_d       = '0;
          timer_d     = '0;
          ubuf_d      = '0;
        end
      end
`ifdef OTP_LOCKOUT_EN
      LOCKOUT: timer_d = timer_q + TW'(1);
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_q    <= '0;
      ubuf_q    <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      att_q     <= '0;
      unlock    <= 1'b0;
      fail      <= 1'b0;
      expired   <= 1'b0;
      reset_sys <= 1'b0;
    end else begin
      code_q    <= code_d;
      ubuf_q    <= ubuf_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      att_q     <= att_d;
      unlock    <= unlock_d;
      fail      <= fail_d;
      expired   <= expired_d;
      reset_sys <= reset_sys_d;
    end
  end

`ifdef OTP_LOCKOUT_EN
  assign locked = (state == LOCKOUT);
`else
  assign locked = 1'b0;
`endif
  assign attempts     = att_q;
  assign user_otp_out = ubuf_q;

endmodule

// File: tb/tb_otp_auth_fsm.sv
// tb_otp_auth_fsm: table-driven cycle vectors plus hand-written timeout, attempt-limit and reset sequences.
module tb_otp_auth_fsm;
  localparam int DIGITS = 4, DIGIT_W = 4, MAX_ATTEMPTS = 3, TIMEOUT_CYCLES = 100, LOCKOUT_CYCLES = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] otp_in;
  logic        otp_valid;
  logic [3:0]  user_digit;
  logic        user_latch, user_clear;
  logic        unlock, fail, expired, reset_sys, locked;
  logic [1:0]  attempts;
  logic [15:0] user_otp_out;
  logic [22:0] outs;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign outs = {unlock, fail, expired, reset_sys, locked, attempts, user_otp_out};

  otp_auth_fsm #(
    .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_ATTEMPTS(MAX_ATTEMPTS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .otp_in(otp_in), .otp_valid(otp_valid),
    .user_digit(user_digit), .user_latch(user_latch), .user_clear(user_clear),
    .unlock(unlock), .fail(fail), .expired(expired), .reset_sys(reset_sys),
    .locked(locked), .attempts(attempts), .user_otp_out(user_otp_out)
  );

  typedef struct {
    logic        valid;
    logic [15:0] otp;
    logic [3:0]  digit;
    logic        latch;
    logic        clear;
    logic [22:0] exp;  // {unlock, fail, expired, reset_sys, locked, attempts, user_otp_out}
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic [15:0] o, input logic [3:0] d,
                              input logic l, input logic c, input logic u, input logic f,
                              input logic e, input logic r, input logic [1:0] a,
                              input logic [15:0] b);
    vec_t t;
    t.valid = v; t.otp = o; t.digit = d; t.latch = l; t.clear = c;
    t.exp   = {u, f, e, r, 1'b0, a, b};
    tbl.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive inputs for one cycle from the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [15:0] o, input logic [3:0] d,
                      input logic l, input logic c);
    @(negedge clk);
    otp_valid = v; otp_in = o; user_digit = d; user_latch = l; user_clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic enter4(input logic [15:0] w);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, w[15-4*i -: 4], 1'b1, 1'b0);
  endtask

  initial begin
    int n_exp, n_lock, bad;

    reset = 1'b0; otp_valid = 1'b0; otp_in = '0; user_digit = '0; user_latch = 1'b0; user_clear = 1'b0;

    //  v  otp       dig  l  c    u  f  e  r  att   user_otp_out
    add(0, 16'h0000, 4'h0, 0, 0,  0, 0, 0, 0, 2'd0, 16'h0000);  // IDLE -> LOAD
    add(1, 16'h3952, 4'h0, 0, 0,  0, 0, 0, 0, 2'd0, 16'h0000);  // code latched, ENTER
    add(0, 16'h0000, 4'h3, 1, 0,  0, 0, 0, 0, 2'd0, 16'h3000);
    add(0, 16'h0000, 4'h9, 1, 0,  0, 0, 0, 0, 2'd0, 16'h3900);
    add(0, 16'h0000, 4'h5, 1, 0,  0, 0, 0, 0, 2'd0, 16'h3950);
    add(0, 16'h0000, 4'h2, 1, 0,  0, 0, 0, 0, 2'd0, 16'h3952);  // -> CHECK
    add(0, 16'h0000, 4'h0, 0, 0,  1, 0, 0, 0, 2'd0, 16'h3952);  // unlock
    add(0, 16'h0000, 4'h0, 0, 0,  0, 0, 0, 0, 2'd0, 16'h0000);  // IDLE clears
    add(1, 16'h3952, 4'h0, 0, 0,  0, 0, 0, 0, 2'd0, 16'h0000);
    add(0, 16'h0000, 4'h1, 1, 0,  0, 0, 0, 0, 2'd0, 16'h1000);
    add(0, 16'h0000, 4'h1, 1, 0,  0, 0, 0, 0, 2'd0, 16'h1100);
    add(0, 16'h0000, 4'h1, 1, 0,  0, 0, 0, 0, 2'd0, 16'h1110);
    add(0, 16'h0000, 4'h1, 1, 0,  0, 0, 0, 0, 2'd0, 16'h1111);
    add(0, 16'h0000, 4'h7, 1, 0,  0, 1, 0, 0, 2'd1, 16'h0000);  // fail; latch in CHECK ignored
    add(0, 16'h0000, 4'h3, 1, 0,  0, 0, 0, 0, 2'd1, 16'h3000);
    add(0, 16'h0000, 4'h9, 1, 0,  0, 0, 0, 0, 2'd1, 16'h3900);
    add(0, 16'h0000, 4'h5, 1, 0,  0, 0, 0, 0, 2'd1, 16'h3950);
    add(0, 16'h0000, 4'h2, 1, 0,  0, 0, 0, 0, 2'd1, 16'h3952);
    add(0, 16'h0000, 4'h0, 0, 0,  1, 0, 0, 0, 2'd1, 16'h3952);
    add(0, 16'h0000, 4'h0, 0, 0,  0, 0, 0, 0, 2'd0, 16'h0000);
    add(0, 16'h0000, 4'h5, 1, 1,  0, 0, 0, 0, 2'd0, 16'h0000);  // latch/clear ignored in LOAD
    add(1, 16'h3952, 4'h0, 0, 0,  0, 0, 0, 0, 2'd0, 16'h0000);
    add(0, 16'h0000, 4'h3, 1, 0,  0, 0, 0, 0, 2'd0, 16'h3000);
    add(0, 16'h0000, 4'h9, 1, 0,  0, 0, 0, 0, 2'd0, 16'h3900);
    add(0, 16'h0000, 4'h0, 0, 1,  0, 0, 0, 0, 2'd0, 16'h0000);  // clear
    add(0, 16'h0000, 4'h4, 1, 1,  0, 0, 0, 0, 2'd0, 16'h0000);  // clear beats latch
    add(0, 16'h0000, 4'h3, 1, 0,  0, 0, 0, 0, 2'd0, 16'h3000);
    add(0, 16'h0000, 4'h9, 1, 0,  0, 0, 0, 0, 2'd0, 16'h3900);
    add(0, 16'h0000, 4'h5, 1, 0,  0, 0, 0, 0, 2'd0, 16'h3950);
    add(0, 16'h0000, 4'h2, 1, 0,  0, 0, 0, 0, 2'd0, 16'h3952);
    add(0, 16'h0000, 4'h0, 0, 0,  1, 0, 0, 0, 2'd0, 16'h3952);
    add(0, 16'h0000, 4'h0, 0, 0,  0, 0, 0, 0, 2'd0, 16'h0000);  // back in LOAD

    #12;
    check("reset_state", 32'(outs), 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].valid, tbl[i].otp, tbl[i].digit, tbl[i].latch, tbl[i].clear);
      check($sformatf("vec%0d", i), 32'(outs), 32'(tbl[i].exp));
    end

    // Timeout: ENTER begins at this edge; expired must appear exactly 100 edges later.
    step(1'b1, 16'h3952, 4'h0, 1'b0, 1'b0);
    n_exp = 0;
    for (int i = 1; i < TIMEOUT_CYCLES; i++) begin
      step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
      if (expired) n_exp++;
    end
    check("early_expired", 32'(n_exp), 32'd0);
    step(1'b0, 16'h0, 4'h3, 1'b1, 1'b0);  // latch on the timeout cycle is dropped
    check("timeout_pulse", 32'(outs), 32'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000}));
    step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    check("expired_one_cycle", 32'(outs), 32'h0);
    step(1'b1, 16'h0C81, 4'h0, 1'b0, 1'b0);  // new code accepted after expiry
    enter4(16'h0C81);
    check("new_code_entered", 32'(user_otp_out), 32'h0C81);
    step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    check("new_code_unlock", 32'(outs), 32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0C81}));
    step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);

    // Attempt limit: three wrong entries against 0C81.
    step(1'b1, 16'h0C81, 4'h0, 1'b0, 1'b0);
    for (int a = 1; a <= MAX_ATTEMPTS; a++) begin
      enter4(16'h1111);
      step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
      check($sformatf("attempt%0d_fail", a), 32'({fail, reset_sys, attempts}),
            32'({1'b1, (a == MAX_ATTEMPTS), 2'(a)}));
    end
`ifdef OTP_LOCKOUT_EN
    check("locked_rise", 32'(locked), 32'd1);
    n_lock = 1;
    bad = 0;
    for (int i = 0; i < 100 && locked; i++) begin
      step(1'b1, 16'h3952, 4'h7, 1'b1, 1'b0);
      if (locked) begin
        n_lock++;
        if (user_otp_out != 16'h0 || unlock || fail) bad++;
      end
    end
    check("lockout_len", 32'(n_lock), 32'(LOCKOUT_CYCLES));
    check("lockout_ignores_input", 32'(bad), 32'd0);
`else
    check("locked_tied_low", 32'(locked), 32'd0);
`endif
    step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    check("attempts_cleared", 32'(outs), 32'h0);

    // Asynchronous reset mid-entry with one failed attempt recorded.
    step(1'b1, 16'h3952, 4'h0, 1'b0, 1'b0);
    enter4(16'h1111);
    step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 4'h3, 1'b1, 1'b0);
    step(1'b0, 16'h0, 4'h9, 1'b1, 1'b0);
    check("pre_reset", 32'(outs), 32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 16'h3900}));
    #1 reset = 1'b0;
    #1;
    check("async_reset", 32'(outs), 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    check("post_reset_load", 32'(outs), 32'h0);
    step(1'b1, 16'h3952, 4'h0, 1'b0, 1'b0);
    enter4(16'h3952);
    step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    check("post_reset_unlock", 32'(outs), 32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h3952}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/otp_auth_fsm.md
# otp_auth_fsm

Parametrised one-time-password authentication controller: captures a generated code from the LFSR code source, collects user-entered digits, compares them, and reports unlock, failure, expiry and lockout. Successor to the fixed 4-digit OTP state machine. Digit count, digit width, attempt limit and timeout are parameters. Adds entry clear, per-attempt failure pulses and an optional timed lockout. Sits between the LFSR code generator and the keypad/display logic.

## Interface
- DIGITS, 4, number of code digits (>=1)
- DIGIT_W, 4, bits per digit
- MAX_ATTEMPTS, 3, wrong entries allowed before lockout/reset (>=1)
- TIMEOUT_CYCLES, 750000000, entry window per attempt in clk cycles (>=2)
- LOCKOUT_CYCLES, 1000000, lockout duration (used only with OTP_LOCKOUT_EN)
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- otp_in  in  DIGITS*DIGIT_W  generated code, first digit in MSBs
- otp_valid  in  1  otp_in valid this cycle
- user_digit  in  DIGIT_W  keypad digit
- user_latch  in  1  single-cycle strobe: accept user_digit
- user_clear  in  1  discard digits entered in current attempt
- unlock  out  1  one-cycle pulse on match
- fail  out  1  one-cycle pulse per mismatch
- expired  out  1  one-cycle pulse on timeout
- reset_sys  out  1  one-cycle pulse when attempt limit reached
- locked  out  1  level, high during LOCKOUT
- attempts  out  $clog2(MAX_ATTEMPTS+1)  wrong attempts this session
- user_otp_out  out  DIGITS*DIGIT_W  entered digits, first in MSBs, unentered digits 0

## Operation
- States: IDLE, LOAD, ENTER, CHECK, LOCKOUT. Reset -> IDLE with all outputs 0, buffers 0, index 0, timer 0, attempts 0.
- IDLE: lasts one cycle. Clears index, timer, attempts, user buffer. Goes to LOAD.
- LOAD: waits for otp_valid. On otp_valid, latches otp_in and goes to ENTER.
- ENTER: timer increments every cycle. Priority order: timeout, then user_clear, then user_latch.
  - Timer == TIMEOUT_CYCLES-1: pulse expired and go to IDLE. A latch in the same cycle is ignored.
  - user_clear: index <= 0 and buffer <= 0. Timer is not reset.
  - user_latch: writes user_digit to slot index (slot 0 = MSBs) and increments index. When this latch fills slot DIGITS-1, go to CHECK.
- CHECK: one cycle. Compares the full user buffer with the latched code.
  - Match: pulse unlock and go to IDLE.
  - Mismatch: pulse fail and increment attempts. If the new attempts == MAX_ATTEMPTS, pulse reset_sys and go to LOCKOUT (or IDLE, see Configuration). Otherwise go to ENTER with index, timer and buffer cleared.
- The latched code is kept across retries. A new code is only taken in LOAD.
- user_latch and user_clear are ignored outside ENTER.
- reset assertion mid-operation returns to IDLE immediately, with all outputs 0.

## Timing
- Pulse outputs are registered, each high for exactly one cycle.
- Final digit sampled at edge k: CHECK occupies the cycle from k to k+1. unlock/fail/reset_sys rise at edge k+1 and fall at edge k+2.
- expired rises on the edge that leaves ENTER. The first ENTER cycle counts as timer 0.
- otp_valid sampled at edge k in LOAD: state is ENTER from edge k.
- attempts updates on the same edge as fail.
- user_otp_out updates on the edge after each latch or clear.
- locked rises with entry to LOCKOUT.

## Configuration
- OTP_LOCKOUT_EN defined:
  - Exhausting attempts enters LOCKOUT with locked=1.
  - A LOCKOUT_CYCLES-cycle counter runs, then the block goes to IDLE and locked falls.
  - otp_valid, user_latch and user_clear are ignored during LOCKOUT.
- Undefined:
  - LOCKOUT state and its counter are absent; locked is tied 0.
  - Exhausting attempts pulses reset_sys and goes directly to IDLE.

## Test plan
Parameters: DIGITS=4, DIGIT_W=4, MAX_ATTEMPTS=3, TIMEOUT_CYCLES=100, LOCKOUT_CYCLES=20.
- otp_in=16'h3952 with otp_valid; enter 3,9,5,2 -> unlock one cycle at edge k+1; fail=0; attempts=0; state back to IDLE.
- Same code; enter 1,1,1,1 then 3,9,5,2 -> one fail pulse, attempts=1, then unlock. user_otp_out=16'h1111 before retry clear.
- Three wrong entries with OTP_LOCKOUT_EN -> three fail pulses, reset_sys at the third. locked=1 for 20 cycles; a user_latch during lockout leaves user_otp_out=0.
- No entry after LOAD -> expired pulse exactly 100 cycles after ENTER begins; no unlock; next otp_valid accepted.
- Enter 3,9 then user_clear, then 3,9,5,2 -> user_otp_out goes 16'h3900 -> 0 -> 16'h3952; unlock.
- Assert reset mid-entry after 2 digits -> all outputs 0 immediately; user_otp_out=0; attempts=0.
